// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: default parameter values,
// FSM state encoding and the helper that computes per-domain release edges.
package reset_seq_pkg;

  localparam int DEF_HOLD_CYCLES = 10;
  localparam int DEF_NUM_DOMAINS = 2;
  localparam int DEF_STAGGER     = 2;
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_TIMEOUT     = 0;

  // Width of the hold/stagger edge counter; wide enough for any practical
  // HOLD_CYCLES + (NUM_DOMAINS-1)*STAGGER.
  localparam int SEQ_CNT_W = 32;

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_STOP    = 2'd3;

  // Edge number (counted from 1 after HOLD entry) on which a domain releases.
  function automatic logic [SEQ_CNT_W-1:0] releaseEdge(input int holdCycles,
                                                       input int domain,
                                                       input int stagger);
    return SEQ_CNT_W'(holdCycles + domain * stagger);
  endfunction

endpackage

// File: rtl/seq_counter.sv
// Loadable, clearable up-counter used to count edges since HOLD entry.
// Clear has priority over load, and load over increment.
module seq_counter
  import reset_seq_pkg::*;
#(
  parameter int W = SEQ_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic [W-1:0] i_loadValue,
  input  logic         i_enable,
  output logic [W-1:0] o_count
);

  // Count register with asynchronous reset to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_count <= '0;
    end else if (i_clear) begin
      o_count <= '0;
    end else if (i_load) begin
      o_count <= i_loadValue;
    end else if (i_enable) begin
      o_count <= o_count + W'(1);
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: holds all domain resets for HOLD_CYCLES edges, releases
// the domains one after another every STAGGER edges, then tracks the run
// length until the core halts, the optional timeout fires, or a restart.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
  parameter int STAGGER     = DEF_STAGGER,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   soft_rst_req,
  input  logic                   halt,
  output logic [NUM_DOMAINS-1:0] dom_reset,
  output logic                   running,
  output logic [CNT_W-1:0]       cycle_cnt,
  output logic                   done,
  output logic                   timed_out
);

  localparam logic [SEQ_CNT_W-1:0] FIRST_EDGE  = releaseEdge(HOLD_CYCLES, 0, STAGGER);
  localparam logic [SEQ_CNT_W-1:0] LAST_EDGE   = releaseEdge(HOLD_CYCLES, NUM_DOMAINS - 1, STAGGER);
  localparam logic [CNT_W-1:0]     TIMEOUT_VAL = CNT_W'(TIMEOUT);

  logic [1:0]             r_state;
  logic [SEQ_CNT_W-1:0]   w_holdCnt;
  logic [SEQ_CNT_W-1:0]   w_nextCnt;
  logic [NUM_DOMAINS-1:0] w_relMask;
  logic [CNT_W-1:0]       w_cntInc;
  logic                   w_counting;
  logic                   w_timeoutHit;

  assign w_counting   = (r_state == ST_HOLD) || (r_state == ST_RELEASE);
  assign w_nextCnt    = w_holdCnt + SEQ_CNT_W'(1);
  assign w_cntInc     = cycle_cnt + CNT_W'(1);
  assign w_timeoutHit = (TIMEOUT != 0) && (w_cntInc == TIMEOUT_VAL);

  seq_counter #(
    .W(SEQ_CNT_W)
  ) u_holdCounter (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (soft_rst_req),
    .i_load      (1'b0),
    .i_loadValue ('0),
    .i_enable    (w_counting),
    .o_count     (w_holdCnt)
  );

  // Domains whose release edge is reached by the edge currently being taken.
  always_comb begin
    w_relMask = '0;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      w_relMask[i] = (w_nextCnt >= releaseEdge(HOLD_CYCLES, i, STAGGER));
    end
  end

  // Sequencer FSM: restart has priority over everything, halt over timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_HOLD;
      dom_reset <= '1;
      running   <= 1'b0;
      cycle_cnt <= '0;
      done      <= 1'b0;
      timed_out <= 1'b0;
    end else if (soft_rst_req) begin
      r_state   <= ST_HOLD;
      dom_reset <= '1;
      running   <= 1'b0;
      cycle_cnt <= '0;
      done      <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      case (r_state)
        ST_HOLD, ST_RELEASE: begin
          dom_reset <= dom_reset & ~w_relMask;
          if (w_nextCnt >= LAST_EDGE) begin
            r_state <= ST_RUN;
            running <= 1'b1;
          end else if (w_nextCnt >= FIRST_EDGE) begin
            r_state <= ST_RELEASE;
          end
        end
        ST_RUN: begin
          if (halt) begin
            r_state <= ST_STOP;
            running <= 1'b0;
            done    <= 1'b1;
          end else if (w_timeoutHit) begin
            r_state   <= ST_STOP;
            running   <= 1'b0;
            timed_out <= 1'b1;
            cycle_cnt <= TIMEOUT_VAL;
          end else if (cycle_cnt != '1) begin
            cycle_cnt <= w_cntInc;
          end
        end
        ST_STOP: begin
        end
        default: begin
          r_state <= ST_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer. Three instances run side by side:
// A uses defaults, B has TIMEOUT=100, C has NUM_DOMAINS=4 and STAGGER=0.
// Stimulus pushes expected output snapshots tagged with the absolute clock
// edge after which they must hold; a monitor on the falling edge pops and
// compares them. Inputs change 1ns after a rising edge.
module tb_reset_sequencer;

  typedef struct {
    string       name;
    int          inst;
    int          atCycle;
    logic [3:0]  dom;
    logic        run;
    logic        done;
    logic        to;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  int   cycleNo = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbQ[$];

  logic        rstA, softA, haltA;
  logic [1:0]  domA;
  logic        runA, doneA, toA;
  logic [31:0] cntA;

  logic        rstB, softB, haltB;
  logic [1:0]  domB;
  logic        runB, doneB, toB;
  logic [31:0] cntB;

  logic        rstC, softC, haltC;
  logic [3:0]  domC;
  logic        runC, doneC, toC;
  logic [31:0] cntC;

  int base;
  int s;
  int s2;
  int base2;

  reset_sequencer dutA (
    .clk(clk), .reset(rstA), .soft_rst_req(softA), .halt(haltA),
    .dom_reset(domA), .running(runA), .cycle_cnt(cntA), .done(doneA), .timed_out(toA)
  );

  reset_sequencer #(.TIMEOUT(100)) dutB (
    .clk(clk), .reset(rstB), .soft_rst_req(softB), .halt(haltB),
    .dom_reset(domB), .running(runB), .cycle_cnt(cntB), .done(doneB), .timed_out(toB)
  );

  reset_sequencer #(.NUM_DOMAINS(4), .STAGGER(0)) dutC (
    .clk(clk), .reset(rstC), .soft_rst_req(softC), .halt(haltC),
    .dom_reset(domC), .running(runC), .cycle_cnt(cntC), .done(doneC), .timed_out(toC)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleNo <= cycleNo + 1;

  task automatic expectAt(input string name, input int inst, input int cyc,
                          input logic [3:0] dom, input logic run, input logic dn,
                          input logic to, input logic [31:0] cnt);
    exp_t e;
    e.name = name; e.inst = inst; e.atCycle = cyc;
    e.dom = dom; e.run = run; e.done = dn; e.to = to; e.cnt = cnt;
    sbQ.push_back(e);
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitUntil(input int cyc);
    while (cycleNo < cyc) applyStimulus(1);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [3:0]  aDom;
    logic        aRun, aDone, aTo;
    logic [31:0] aCnt;
    case (e.inst)
      0:       begin aDom = 4'(domA); aRun = runA; aDone = doneA; aTo = toA; aCnt = cntA; end
      1:       begin aDom = 4'(domB); aRun = runB; aDone = doneB; aTo = toB; aCnt = cntB; end
      default: begin aDom = domC;     aRun = runC; aDone = doneC; aTo = toC; aCnt = cntC; end
    endcase
    checks++;
    if (aDom !== e.dom || aRun !== e.run || aDone !== e.done || aTo !== e.to || aCnt !== e.cnt) begin
      errors++;
      $display("[TB] FAIL %s @cyc %0d: got dom=%b run=%b done=%b to=%b cnt=%0d, want dom=%b run=%b done=%b to=%b cnt=%0d",
               e.name, cycleNo, aDom, aRun, aDone, aTo, aCnt, e.dom, e.run, e.done, e.to, e.cnt);
    end
  endtask

  // Monitor: compare every snapshot due at this edge, flag any that were missed.
  always @(negedge clk) begin
    int idx;
    exp_t e;
    idx = 0;
    while (idx < sbQ.size()) begin
      e = sbQ[idx];
      if (e.atCycle < cycleNo) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s: snapshot for cyc %0d not compared (now %0d)", e.name, e.atCycle, cycleNo);
        sbQ.delete(idx);
      end else if (e.atCycle == cycleNo) begin
        checkOutput(e);
        sbQ.delete(idx);
      end else begin
        idx++;
      end
    end
  end

  // Watchdog so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got cyc=%0d, want finish before time limit", cycleNo);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstA = 1'b1; softA = 1'b0; haltA = 1'b0;
    rstB = 1'b1; softB = 1'b0; haltB = 1'b0;
    rstC = 1'b1; softC = 1'b0; haltC = 1'b0;

    // Reset values while reset is held.
    applyStimulus(1);
    expectAt("rstA", 0, cycleNo, 4'b0011, 0, 0, 0, 0);
    expectAt("rstB", 1, cycleNo, 4'b0011, 0, 0, 0, 0);
    expectAt("rstC", 2, cycleNo, 4'b1111, 0, 0, 0, 0);
    applyStimulus(2);
    rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;
    base = cycleNo;

    // Staggered release for A, simultaneous release for C.
    expectAt("holdA9",   0, base + 9,  4'b0011, 0, 0, 0, 0);
    expectAt("holdC9",   2, base + 9,  4'b1111, 0, 0, 0, 0);
    expectAt("relA10",   0, base + 10, 4'b0010, 0, 0, 0, 0);
    expectAt("relC10",   2, base + 10, 4'b0000, 1, 0, 0, 0);
    expectAt("relA11",   0, base + 11, 4'b0010, 0, 0, 0, 0);
    expectAt("runA12",   0, base + 12, 4'b0000, 1, 0, 0, 0);
    expectAt("runB12",   1, base + 12, 4'b0000, 1, 0, 0, 0);
    expectAt("runA13",   0, base + 13, 4'b0000, 1, 0, 0, 1);
    // Halt sampled on the 26th edge of RUN: 25 counted edges precede it.
    expectAt("haltA",    0, base + 38, 4'b0000, 0, 1, 0, 25);
    expectAt("stopHold", 0, base + 88, 4'b0000, 0, 1, 0, 25);
    expectAt("toB99",    1, base + 111, 4'b0000, 1, 0, 0, 99);
    expectAt("toB",      1, base + 112, 4'b0000, 0, 0, 1, 100);
    expectAt("toBHold",  1, base + 130, 4'b0000, 0, 0, 1, 100);

    waitUntil(base + 37);
    haltA = 1'b1;
    applyStimulus(1);
    haltA = 1'b0;
    // A halt while stopped must have no effect.
    waitUntil(base + 40);
    haltA = 1'b1;
    applyStimulus(1);
    haltA = 1'b0;

    // B: restart, then halt on the very edge the timeout would fire.
    waitUntil(base + 131);
    softB = 1'b1;
    applyStimulus(1);
    softB = 1'b0;
    s = cycleNo;
    expectAt("softB",    1, s,       4'b0011, 0, 0, 0, 0);
    expectAt("haltVsTo", 1, s + 112, 4'b0000, 0, 1, 0, 99);
    waitUntil(s + 111);
    haltB = 1'b1;
    applyStimulus(1);
    haltB = 1'b0;

    // A: restart held for 4 edges keeps the hold count at zero.
    softA = 1'b1;
    expectAt("softA1", 0, cycleNo + 1, 4'b0011, 0, 0, 0, 0);
    applyStimulus(4);
    softA = 1'b0;
    s = cycleNo;
    expectAt("softA4",  0, s,      4'b0011, 0, 0, 0, 0);
    expectAt("reA9",    0, s + 9,  4'b0011, 0, 0, 0, 0);
    expectAt("reA10",   0, s + 10, 4'b0010, 0, 0, 0, 0);
    expectAt("reA12",   0, s + 12, 4'b0000, 1, 0, 0, 0);
    expectAt("runA40",  0, s + 52, 4'b0000, 1, 0, 0, 40);

    // A: restart in RUN at count 40.
    waitUntil(s + 52);
    softA = 1'b1;
    applyStimulus(1);
    softA = 1'b0;
    s2 = cycleNo;
    expectAt("softRun", 0, s2,      4'b0011, 0, 0, 0, 0);
    expectAt("re2A10",  0, s2 + 10, 4'b0010, 0, 0, 0, 0);

    // A: async reset between edges while one domain is already released.
    waitUntil(s2 + 11);
    rstA = 1'b1;
    expectAt("asyncRst", 0, s2 + 11, 4'b0011, 0, 0, 0, 0);
    expectAt("rstHeld",  0, s2 + 12, 4'b0011, 0, 0, 0, 0);
    applyStimulus(2);
    rstA = 1'b0;
    base2 = cycleNo;
    expectAt("post9",  0, base2 + 9,  4'b0011, 0, 0, 0, 0);
    expectAt("post10", 0, base2 + 10, 4'b0010, 0, 0, 0, 0);
    expectAt("post12", 0, base2 + 12, 4'b0000, 1, 0, 0, 0);
    waitUntil(base2 + 14);

    while (sbQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: snapshot for cyc %0d never compared (now %0d)",
               sbQ[0].name, sbQ[0].atCycle, cycleNo);
      void'(sbQ.pop_front());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 10: rising edges all domain resets stay asserted after reset release; legal range >=1.
REQ-002 SHALL have parameter NUM_DOMAINS, default 2: number of independently released reset domains; legal range 1..8.
REQ-003 SHALL have parameter STAGGER, default 2: edges between successive domain releases; 0 means all domains release on the same edge.
REQ-004 SHALL have parameter CNT_W, default 32: width of cycle_cnt.
REQ-005 SHALL have parameter TIMEOUT, default 0: run-cycle limit; 0 disables the limit.
REQ-006 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port soft_rst_req, input, 1: synchronous restart request, sampled on the edge.
REQ-009 SHALL have port halt, input, 1: end-of-program indication from the core, sampled on the edge.
REQ-010 SHALL have port dom_reset, output, NUM_DOMAINS: per-domain active-high reset; bit i drives domain i.
REQ-011 SHALL have port running, output, 1: high while all domains are released and the run is live.
REQ-012 SHALL have port cycle_cnt, output, CNT_W: number of edges spent in RUN.
REQ-013 SHALL have ports done, output, 1 and timed_out, output, 1: sticky run-end status flags.

Function
REQ-014 SHALL implement FSM states HOLD, RELEASE, RUN and STOP.
REQ-015 HOLD SHALL keep all dom_reset bits at 1, count edges, and enter RELEASE on edge HOLD_CYCLES after entry.
REQ-016 dom_reset[i] SHALL deassert on edge HOLD_CYCLES + i*STAGGER after HOLD entry, numbered from edge 1.
REQ-017 Entry to RUN and the assertion of running SHALL happen on the same edge that releases domain NUM_DOMAINS-1.
REQ-018 cycle_cnt SHALL clear on HOLD entry.
REQ-019 In RUN, cycle_cnt SHALL increment by 1 each edge.
REQ-020 With TIMEOUT=0, cycle_cnt SHALL saturate at all-ones.
REQ-021 halt high in RUN SHALL, on that edge, enter STOP, drop running, set done=1, and leave cycle_cnt unincremented.
REQ-022 With TIMEOUT>0, on the edge where cycle_cnt would reach TIMEOUT, the block SHALL enter STOP, set cycle_cnt=TIMEOUT, set timed_out=1 and drop running.
REQ-023 If halt and timeout coincide on one edge, halt SHALL win: done=1, timed_out=0.
REQ-024 In STOP, dom_reset SHALL stay 0 and cycle_cnt, done and timed_out SHALL hold until restart.
REQ-025 soft_rst_req high in any state SHALL, on that edge, enter HOLD, set all dom_reset bits to 1, and clear running, done, timed_out and cycle_cnt; it overrides a simultaneous halt or timeout.
REQ-026 halt SHALL be ignored outside RUN.
REQ-027 soft_rst_req asserted continuously SHALL keep the block in HOLD with the hold count at 0.

Reset
REQ-028 reset high SHALL immediately, without waiting for clk, force state HOLD, hold count 0, dom_reset all ones, running=0, cycle_cnt=0, done=0 and timed_out=0.
REQ-029 Reset release SHALL be synchronous: the first clk edge after reset falls is counted as edge 1 of HOLD.
REQ-030 reset asserted mid-RUN or mid-RELEASE SHALL discard all progress, with no partial domain release surviving.

Structure
REQ-031 FSM state encoding and default parameter values SHALL live in shared package reset_seq_pkg.
REQ-032 The edge/stagger counter SHALL be one sub-module, seq_counter (loadable and clearable up-counter).
REQ-033 The block SHALL be instantiated in the system top so that dom_reset drives the mips core resets; it replaces fixed-delay reset in benches.

Verification
REQ-034 Default parameters, reset high for 3 edges then low -> dom_reset 2'b11 until edge 10; 2'b10 from edge 10; 2'b00 and running=1 from edge 12.
REQ-035 Default parameters, halt pulsed on edge 12+25 -> done=1, running=0, cycle_cnt=25, held for 50 further edges.
REQ-036 TIMEOUT=100, halt never asserted -> timed_out=1, cycle_cnt=100, done=0, running=0.
REQ-037 TIMEOUT=100, halt on the timeout edge -> done=1, timed_out=0.
REQ-038 soft_rst_req in RUN at cycle_cnt=40 -> next edge dom_reset=2'b11 and cycle_cnt=0; release repeats at +10/+12 edges.
REQ-039 reset asserted between clk edges during RELEASE (dom_reset=2'b10) -> dom_reset=2'b11 immediately; NUM_DOMAINS=4, STAGGER=0 -> all bits release together on edge 10.
